// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate extender pipeline stage.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_BRSH  = 2'd3
  } imm_mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: sign, zero, upper or branch-shifted.
// Optional macro IMMEXT_BRANCH_SHIFT_EN enables the branch shift for mode 3.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]  out_result
);

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_upper;

  assign w_sign  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign w_zero  = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign w_upper = {in_imm, {(OUT_W-IN_W){1'b0}}};

  // Without the macro, mode 3 falls back to plain sign extension.
  always_comb begin
    out_result = w_sign;
    case (imm_mode_t'(in_mode))
      IMM_SIGN:  out_result = w_sign;
      IMM_ZERO:  out_result = w_zero;
      IMM_UPPER: out_result = w_upper;
`ifdef IMMEXT_BRANCH_SHIFT_EN
      IMM_BRSH:  out_result = w_sign << 2;
`else
      IMM_BRSH:  out_result = w_sign;
`endif
      default:   out_result = w_sign;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a two-entry skid buffer and flush.
// Optional macro IMMEXT_BRANCH_SHIFT_EN enables the branch-shift mode.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  logic [OUT_W-1:0] w_extData;
  logic             w_accept;
  logic             w_mainFree;

  logic             r_mainValid;
  logic [OUT_W-1:0] r_mainData;
  logic [TAG_W-1:0] r_mainTag;
  logic             r_skidValid;
  logic [OUT_W-1:0] r_skidData;
  logic [TAG_W-1:0] r_skidTag;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm     (in_imm),
    .in_mode    (in_mode),
    .out_result (w_extData)
  );

  // Ready comes only from the skid flag so out_ready never reaches in_ready.
  assign in_ready   = !r_skidValid;
  assign w_accept   = in_valid && in_ready;
  assign w_mainFree = !r_mainValid || out_ready;

  assign out_valid = r_mainValid;
  assign out_data  = r_mainData;
  assign out_tag   = r_mainTag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainValid <= 1'b0;
      r_mainData  <= '0;
      r_mainTag   <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
      r_skidTag   <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (w_mainFree) begin
      // Skid holds the older entry, so it refills main before any new input.
      if (r_skidValid) begin
        r_mainValid <= 1'b1;
        r_mainData  <= r_skidData;
        r_mainTag   <= r_skidTag;
        r_skidValid <= 1'b0;
      end else if (w_accept) begin
        r_mainValid <= 1'b1;
        r_mainData  <= w_extData;
        r_mainTag   <= in_tag;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidValid <= 1'b1;
      r_skidData  <= w_extData;
      r_skidTag   <= in_tag;
    end
  end

endmodule
